jt51_host_port: RTL and testbench
=================================

Name: jt51_host_port

Overview:
CPU-side bus responder for the YM2151-compatible synth core. It accepts cs_n/wr_n/a0/d_in writes from a host sequencer or the trackball control FSM, latches the register address, and issues one-cycle register-write strobes into the core register file. It also owns the busy flag, the timer flags and irq_n, and drives the status byte on d_out that host sequencers poll before each write.

Parameters:
BUSY_CYCLES, 64, clocks busy stays high after an accepted data write (>=2)
CW, $clog2(BUSY_CYCLES+1), busy counter width (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cs_n  in  1  chip select, active low
wr_n  in  1  write strobe, active low
a0  in  1  0 = address phase, 1 = data phase
d_in  in  8  host write data
d_out  out  8  status: {busy, 5'b0, flag_b, flag_a}
irq_n  out  1  interrupt, active low
reg_we  out  1  one-cycle register write strobe to core
reg_addr  out  8  register address qualified by reg_we
reg_data  out  8  register data qualified by reg_we
tim_a_ovf  in  1  timer A overflow pulse from core
tim_b_ovf  in  1  timer B overflow pulse from core
ct1  out  1  reg 0x1B bit 6
ct2  out  1  reg 0x1B bit 7
wr_drop  out  1  one-cycle pulse: data write rejected because busy

Behaviour:
- Reset values: d_out=0, irq_n=1, reg_we=0, reg_addr=0, reg_data=0, ct1=ct2=0, wr_drop=0. Internal address latch, flags, irq enables and busy counter are also 0.
- Strobe detect: acc = !cs_n & !wr_n & !wr_q, where wr_q is the registered previous (!cs_n & !wr_n). Exactly one access per low pulse, whatever its length.
- Address phase (acc & !a0):
  - addr_lat <= d_in. Accepted even while busy.
  - No reg_we pulse and no change to busy.
- Data phase (acc & a0 & !busy):
  - Next cycle: reg_we=1, reg_addr=addr_lat, reg_data=d_in. Latency 1.
  - Busy counter loads BUSY_CYCLES, so d_out[7]=1 from the cycle after the strobe.
  - A host that leaves a one-cycle gap and then polls sees busy.
- Data phase while busy (acc & a0 & busy):
  - Write is dropped; no reg_we.
  - wr_drop pulses 1 cycle. Busy counter is not reloaded.
- Busy FSM states: IDLE and BUSY.
  - IDLE -> BUSY on an accepted data write.
  - In BUSY the counter decrements each clock; BUSY -> IDLE when it reaches 1 (busy is high for exactly BUSY_CYCLES cycles).
  - d_out[7] = (state==BUSY).
- Address 0x14 accepted data write, decoded in the same cycle reg_we is issued:
  - bits[3:2] are stored as irqen_b / irqen_a.
  - bit4 clears flag_a; bit5 clears flag_b.
  - bits[1:0] pass through to the core via reg_data only.
- Address 0x1B accepted data write: ct2<=d_in[7], ct1<=d_in[6].
- Timer flags:
  - A tim_a_ovf pulse sets flag_a; a tim_b_ovf pulse sets flag_b.
  - If set and clear land on the same cycle, set wins.
  - Flags are visible in d_out[1:0] one cycle after the event.
- irq_n (registered) = !((flag_a & irqen_a) | (flag_b & irqen_b)).
- All outputs are registered; there is no combinational path from bus inputs to outputs.
- Reset mid-operation: everything returns to its reset value immediately. A pending busy period is abandoned and the address latch reads 0.

Decomposition:
- Shared package jt51_host_pkg holds:
  - register address constants REG_TIMER_CTRL=8'h14, REG_CT=8'h1B, REG_KEYON=8'h08, REG_NOTE_BASE=8'h28;
  - STATUS_BUSY_BIT=7;
  - busy_state_t enum {IDLE, BUSY}.
- One natural sub-module, jt51_busy_timer: the load/decrement counter plus the IDLE/BUSY state. Interface: load, busy.

Test Plan:
- Write addr 0x28 then data 0x4A (one-cycle strobes, one-cycle gaps) -> one reg_we pulse with reg_addr=0x28, reg_data=0x4A. d_out[7]=1 for exactly 64 cycles starting the cycle after the data strobe.
- Data write 0x11 while busy -> no reg_we, wr_drop pulses once, busy end time unchanged. Retry after busy drops -> accepted.
- Hold cs_n=wr_n=0 with a0=1 for 10 cycles -> exactly one reg_we.
- Write 0x14 <- 0x04, then pulse tim_a_ovf -> d_out[0]=1 and irq_n=0 the next cycle. Write 0x14 <- 0x14 -> flag_a=0, irq_n=1. Pulse tim_b_ovf with irqen_b=0 -> d_out[1]=1, irq_n stays 1.
- tim_a_ovf in the same cycle as a clearing 0x14 <- 0x14 write -> flag_a remains 1.
- Write 0x1B <- 0xC0 -> ct1=ct2=1. Assert rst mid-busy -> d_out=0, ct1=ct2=0, irq_n=1 immediately.

Source files
------------

// File: rtl/jt51_host_pkg.sv
// Shared constants and types for the jt51 CPU-side host port.
// Register addresses decoded by the port and the busy-state encoding.
package jt51_host_pkg;

    localparam logic [7:0] REG_TIMER_CTRL = 8'h14;
    localparam logic [7:0] REG_CT         = 8'h1B;
    localparam logic [7:0] REG_KEYON      = 8'h08;
    localparam logic [7:0] REG_NOTE_BASE  = 8'h28;

    localparam int STATUS_BUSY_BIT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } busy_state_t;

endpackage

// File: rtl/jt51_busy_timer.sv
// Busy window generator: a load starts a BUSY_CYCLES-long busy period.
// Loads that arrive while already busy are ignored by construction.
module jt51_busy_timer
    import jt51_host_pkg::*;
#(
    parameter int BUSY_CYCLES = 64,
    parameter int CW          = $clog2(BUSY_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    busy_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The count value 1 marks the final busy cycle, so busy lasts exactly BUSY_CYCLES clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = BUSY;
                    cnt_d   = CW'(BUSY_CYCLES);
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/jt51_host_port.sv
// CPU-side bus responder for the YM2151-compatible core: address latch, write
// strobes, busy/timer status byte, timer IRQ and the CT output pins.
module jt51_host_port
    import jt51_host_pkg::*;
#(
    parameter int BUSY_CYCLES = 64,
    parameter int CW          = $clog2(BUSY_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       irq_n,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    input  logic       tim_a_ovf,
    input  logic       tim_b_ovf,
    output logic       ct1,
    output logic       ct2,
    output logic       wr_drop
);

    logic       wr_q, wr_d;
    logic [7:0] addr_lat_q, addr_lat_d;
    logic       reg_we_q, reg_we_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_data_q, reg_data_d;
    logic       wr_drop_q, wr_drop_d;
    logic       flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic       irqen_a_q, irqen_a_d, irqen_b_q, irqen_b_d;
    logic       ct1_q, ct1_d, ct2_q, ct2_d;
    logic       irq_n_q, irq_n_d;

    logic busy;
    logic acc, data_ok, wr_timer, wr_ct;

    jt51_busy_timer #(
        .BUSY_CYCLES (BUSY_CYCLES),
        .CW          (CW)
    ) u_busy (
        .clk  (clk),
        .rst  (rst),
        .load (data_ok),
        .busy (busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q       <= 1'b0;
            addr_lat_q <= '0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            wr_drop_q  <= 1'b0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            irqen_a_q  <= 1'b0;
            irqen_b_q  <= 1'b0;
            ct1_q      <= 1'b0;
            ct2_q      <= 1'b0;
            irq_n_q    <= 1'b1;
        end else begin
            wr_q       <= wr_d;
            addr_lat_q <= addr_lat_d;
            reg_we_q   <= reg_we_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            wr_drop_q  <= wr_drop_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            irqen_a_q  <= irqen_a_d;
            irqen_b_q  <= irqen_b_d;
            ct1_q      <= ct1_d;
            ct2_q      <= ct2_d;
            irq_n_q    <= irq_n_d;
        end
    end

    // Control registers are decoded from the issued strobe, so they change the cycle after reg_we.
    always_comb begin
        wr_d     = !cs_n && !wr_n;
        acc      = wr_d && !wr_q;
        data_ok  = acc && a0 && !busy;
        wr_timer = reg_we_q && (reg_addr_q == REG_TIMER_CTRL);
        wr_ct    = reg_we_q && (reg_addr_q == REG_CT);

        addr_lat_d = (acc && !a0) ? d_in : addr_lat_q;
        reg_we_d   = data_ok;
        reg_addr_d = data_ok ? addr_lat_q : reg_addr_q;
        reg_data_d = data_ok ? d_in : reg_data_q;
        wr_drop_d  = acc && a0 && busy;

        irqen_a_d = wr_timer ? reg_data_q[2] : irqen_a_q;
        irqen_b_d = wr_timer ? reg_data_q[3] : irqen_b_q;
        ct1_d     = wr_ct ? reg_data_q[6] : ct1_q;
        ct2_d     = wr_ct ? reg_data_q[7] : ct2_q;

        // A timer overflow beats a simultaneous software clear.
        flag_a_d = tim_a_ovf || (flag_a_q && !(wr_timer && reg_data_q[4]));
        flag_b_d = tim_b_ovf || (flag_b_q && !(wr_timer && reg_data_q[5]));
        irq_n_d  = !((flag_a_d && irqen_a_d) || (flag_b_d && irqen_b_d));
    end

    always_comb begin
        d_out                  = '0;
        d_out[STATUS_BUSY_BIT] = busy;
        d_out[1]               = flag_b_q;
        d_out[0]               = flag_a_q;
    end

    assign irq_n    = irq_n_q;
    assign reg_we   = reg_we_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign ct1      = ct1_q;
    assign ct2      = ct2_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_jt51_host_port.sv
// Scoreboard bench for jt51_host_port: stimulus pushes expected register
// writes / drops, a negedge monitor pops and compares whenever the DUT emits one.
module tb_jt51_host_port;

    localparam int BUSY_CYCLES = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n, wr_n, a0;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       irq_n, reg_we, ct1, ct2, wr_drop;
    logic [7:0] reg_addr, reg_data;
    logic       tim_a_ovf, tim_b_ovf;

    typedef struct {
        bit         is_drop;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         fails  = 0;
    logic [7:0] model_addr = 8'h00;
    int         busy_run = 0;
    int         last_busy_len = 0;

    jt51_host_port #(.BUSY_CYCLES(BUSY_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .d_in      (d_in),
        .d_out     (d_out),
        .irq_n     (irq_n),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .tim_a_ovf (tim_a_ovf),
        .tim_b_ovf (tim_b_ovf),
        .ct1       (ct1),
        .ct2       (ct2),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access held low for `hold` cycles; expectation is pushed before the sampling edge.
    task automatic applyStimulus(input bit a0v, input logic [7:0] d, input int hold, input bit accept);
        exp_t e;
        cs_n = 1'b0;
        wr_n = 1'b0;
        a0   = a0v;
        d_in = d;
        if (!a0v) begin
            model_addr = d;
        end else begin
            e.is_drop = !accept;
            e.addr    = accept ? model_addr : 8'h00;
            e.data    = accept ? d : 8'h00;
            sb_q.push_back(e);
        end
        repeat (hold) tick();
        cs_n = 1'b1;
        wr_n = 1'b1;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4 * BUSY_CYCLES; i++) begin
            @(negedge clk);
            if (!d_out[7]) break;
        end
        checkOutput("busy_timeout", {31'b0, d_out[7]}, 32'd0);
        tick();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (reg_we || wr_drop)) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL sb_unexpected: reg_we=%0b wr_drop=%0b with no pending expectation", reg_we, wr_drop);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_kind_drop", {31'b0, wr_drop}, {31'b0, e.is_drop});
                checkOutput("sb_kind_we", {31'b0, reg_we}, {31'b0, !e.is_drop});
                if (!e.is_drop) begin
                    checkOutput("sb_reg_addr", {24'b0, reg_addr}, {24'b0, e.addr});
                    checkOutput("sb_reg_data", {24'b0, reg_data}, {24'b0, e.data});
                end
            end
        end
    end

    // Busy window length tracker
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            busy_run = 0;
        end else if (d_out[7]) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
    end

    initial begin
        rst = 1'b1;
        cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; d_in = 8'h00;
        tim_a_ovf = 1'b0; tim_b_ovf = 1'b0;
        repeat (3) tick();
        checkOutput("rst_d_out", {24'b0, d_out}, 32'h0);
        checkOutput("rst_irq_n", {31'b0, irq_n}, 32'd1);
        checkOutput("rst_reg_we", {31'b0, reg_we}, 32'd0);
        checkOutput("rst_reg_addr", {24'b0, reg_addr}, 32'h0);
        checkOutput("rst_reg_data", {24'b0, reg_data}, 32'h0);
        checkOutput("rst_ct", {30'b0, ct2, ct1}, 32'd0);
        checkOutput("rst_wr_drop", {31'b0, wr_drop}, 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] basic address/data write and busy window");
        applyStimulus(1'b0, 8'h28, 1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h4A, 1, 1'b1);
        checkOutput("busy_after_strobe", {31'b0, d_out[7]}, 32'd1);
        tick();
        checkOutput("busy_poll_after_gap", {31'b0, d_out[7]}, 32'd1);
        waitIdle();
        checkOutput("busy_len", last_busy_len, BUSY_CYCLES);

        $display("[TB] write while busy is dropped, retry accepted");
        applyStimulus(1'b1, 8'h55, 1, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b1, 8'h11, 1, 1'b0);
        waitIdle();
        checkOutput("busy_len_after_drop", last_busy_len, BUSY_CYCLES);
        applyStimulus(1'b1, 8'h11, 1, 1'b1);
        waitIdle();

        $display("[TB] long strobe gives one access");
        applyStimulus(1'b1, 8'h33, 10, 1'b1);
        waitIdle();

        $display("[TB] timer flags and irq");
        applyStimulus(1'b0, 8'h14, 1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h04, 1, 1'b1);
        repeat (2) tick();
        tim_a_ovf = 1'b1;
        tick();
        tim_a_ovf = 1'b0;
        checkOutput("flag_a_set", {30'b0, d_out[1:0]}, 32'd1);
        checkOutput("irq_a_low", {31'b0, irq_n}, 32'd0);
        waitIdle();
        applyStimulus(1'b0, 8'h14, 1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h14, 1, 1'b1);
        repeat (2) tick();
        checkOutput("flag_a_clear", {30'b0, d_out[1:0]}, 32'd0);
        checkOutput("irq_released", {31'b0, irq_n}, 32'd1);
        tim_b_ovf = 1'b1;
        tick();
        tim_b_ovf = 1'b0;
        checkOutput("flag_b_set", {30'b0, d_out[1:0]}, 32'd2);
        checkOutput("irq_b_masked", {31'b0, irq_n}, 32'd1);
        waitIdle();

        $display("[TB] set beats clear");
        tim_a_ovf = 1'b1;
        tick();
        applyStimulus(1'b1, 8'h14, 1, 1'b1);
        tick();
        tim_a_ovf = 1'b0;
        checkOutput("set_wins_a", {31'b0, d_out[0]}, 32'd1);
        tick();
        checkOutput("set_wins_a_hold", {31'b0, d_out[0]}, 32'd1);
        checkOutput("set_wins_irq", {31'b0, irq_n}, 32'd0);
        waitIdle();

        $display("[TB] CT pins and reset mid-busy");
        applyStimulus(1'b0, 8'h1B, 1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'hC0, 1, 1'b1);
        repeat (2) tick();
        checkOutput("ct_set", {30'b0, ct2, ct1}, 32'd3);
        checkOutput("busy_before_rst", {31'b0, d_out[7]}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_d_out", {24'b0, d_out}, 32'h0);
        checkOutput("midrst_ct", {30'b0, ct2, ct1}, 32'd0);
        checkOutput("midrst_irq_n", {31'b0, irq_n}, 32'd1);
        checkOutput("midrst_reg_addr", {24'b0, reg_addr}, 32'h0);
        sb_q.delete();
        model_addr = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 8'h5A, 1, 1'b1);
        waitIdle();
        repeat (3) tick();
        checkOutput("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
